xbus_ddr_cache: RTL and testbench
=================================

// Module: xbus_ddr_cache
// PURPOSE
//  Parametrised successor to the LM-3 xbus SDRAM path: a direct-mapped, write-through, no-write-allocate read cache.
//  Sits between the CADR xbus_sdram port and the MiSTer DDR3 Avalon-style port, in a single clock domain.
//  Packs two 32-bit xbus words per 64-bit DDR word and uses byte enables so writes never clobber the other half.
//  Addresses at or above CACHE_LIMIT bypass the cache (I/O-style space).
// PARAMETERS
//  ADDR_W      22         xbus word-address width
//  INDEX_W     12         line-index bits; 2**INDEX_W lines of 64 bits (32 KB default)
//  CACHE_LIMIT 22'h3C0000 first uncacheable xbus address
//  DDR_BASE    29'h0      64-bit-word offset added to every DDR address
// PORTS
//  cpu_clk          in   1        clock for the whole block; DDRAM_CLK = cpu_clk
//  reset            in   1        sync, active-high
//  sdram_addr       in   ADDR_W   xbus word address
//  sdram_data_in    in   32       write data
//  sdram_req        in   1        read request, level; held until sdram_ready
//  sdram_write      in   1        write request, level; held until sdram_done
//  sdram_data_out   out  32       read data; valid while sdram_ready=1
//  sdram_ready      out  1        read complete
//  sdram_done       out  1        write complete
//  DDRAM_BUSY       in   1        waitrequest; a command is accepted when RD|WE=1 and BUSY=0
//  DDRAM_ADDR       out  29       64-bit word address
//  DDRAM_BURSTCNT   out  8        constant 1
//  DDRAM_RD/WE      out  1 each   command strobes, held until accepted
//  DDRAM_DIN        out  64       {sdram_data_in, sdram_data_in}
//  DDRAM_BE         out  8        addr[0] ? 8'hF0 : 8'h0F; 8'hFF for reads
//  DDRAM_DOUT       in   64       read data
//  DDRAM_DOUT_READY in   1        read data valid
//  stat_hits/misses out  32 each  statistics counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output 0 (BURSTCNT=1); state<=INIT; sdram_data_out=32'h0. Reset is legal mid-transaction.
//  INIT: walks index 0..2**INDEX_W-1, clearing valid bits, one line per cycle, then goes to IDLE. Requests wait here.
//  Line address:
//    DDR word = sdram_addr[ADDR_W-1:1] + DDR_BASE; index = DDR word[INDEX_W-1:0]; tag = remaining upper bits.
//    Half-select = sdram_addr[0]; 1 selects bits [63:32].
//  IDLE:
//    Accepts a request only if the previous ack has been dropped.
//    If sdram_req and sdram_write are both high, the read wins.
//    Latches addr/data; cacheable read -> LOOKUP, uncacheable read -> MISS_RD, write -> WR.
//  LOOKUP (1 cycle, tag/data RAM read):
//    valid && tag match -> ACK with the selected half as data, hit counter +1.
//    Otherwise -> MISS_RD, miss counter +1.
//  MISS_RD: RD=1 until BUSY=0, then -> MISS_WAIT.
//  MISS_WAIT:
//    On DOUT_READY, capture the selected half into sdram_data_out.
//    If cacheable, also fill the line: data, tag, valid=1. Then -> ACK.
//    DOUT_READY outside MISS_WAIT is ignored (stale data after reset).
//  WR:
//    WE=1 until BUSY=0 (write-through), then -> ACK.
//    On a cacheable hit, the cached half is updated in the accept cycle; a miss does not allocate.
//    The tag lookup for the write happens in the first WR cycle, and WE is not raised before it completes.
//  ACK:
//    ready (read) or done (write) held at 1 while the originating request stays high.
//    Request low -> ack 0, -> IDLE.
//  Latency from request sampled to ack: hit = 2 cycles; miss = 1 cycle after DOUT_READY; write = 1 cycle after accept.
//  Counters wrap modulo 2**32.
// CONFIGURATION
//  XBUS_CACHE_STATS_EN defined:
//    stat_hits/stat_misses count cacheable read hits/misses.
//    Cleared by reset and saturate-free (wrap).
//  Undefined: both ports tied to 32'h0 and no counter logic is generated.
// STRUCTURE
//  Package lm3_mem_pkg:
//    cache_state_t enum: INIT, IDLE, LOOKUP, MISS_RD, MISS_WAIT, WR, ACK.
//    Constants: DDR_BE_LO=8'h0F, DDR_BE_HI=8'hF0, DDR_BE_ALL=8'hFF.
//  Sub-module xbus_cache_ram:
//    Simple dual-port inferred block RAM with 1-cycle registered read and per-32-bit write enable.
//    One instance holds {valid, tag}; one holds the 64-bit data.
// TESTING
//  Cold read of addr 0x000010 (DDR returns 64'hAAAA_BBBB_1111_2222)
//    -> one RD at DDRAM_ADDR 0x8; ready with data 0x1111_2222; misses=1.
//  Re-read of 0x000011 -> no DDR RD; ready 2 cycles after req; data 0xAAAA_BBBB; hits=1.
//  Write 0xDEAD_BEEF to 0x000011 while BUSY is high for 3 cycles
//    -> WE held 4 cycles; BE=8'hF0; done after accept; a subsequent read of 0x11 hits and returns 0xDEAD_BEEF.
//  Read of 0x3C0002 twice -> two DDR RDs; hit/miss counters unchanged.
//  Assert reset while in MISS_WAIT, then deliver a late DOUT_READY
//    -> ignored; after INIT, a read of the same address misses.
//  sdram_req and sdram_write raised in the same cycle -> the read is serviced first and the write after the read ack drops.

Source files
------------

// File: rtl/xbus_ddr_cache_pkg.sv
// Shared types and constants for the xbus-to-DDR3 read cache.
// The optional statistics counters in the top are enabled by XBUS_CACHE_STATS_EN.
package lm3_mem_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    MISS_RD,
    MISS_WAIT,
    WR,
    ACK
  } cache_state_t;

  localparam logic [7:0] DDR_BE_LO  = 8'h0F;
  localparam logic [7:0] DDR_BE_HI  = 8'hF0;
  localparam logic [7:0] DDR_BE_ALL = 8'hFF;

  function automatic logic [7:0] ddr_be(input logic half_hi);
    return half_hi ? DDR_BE_HI : DDR_BE_LO;
  endfunction

endpackage

// File: rtl/xbus_ddr_cache_if.sv
// xbus request port plus DDR3 Avalon-style port of the cache.
// slave is the cache's view, master is the surrounding system's view.
interface xbus_ddr_cache_if #(
  parameter int ADDR_W = 22
);
  logic [ADDR_W-1:0] sdram_addr;
  logic [31:0]       sdram_data_in;
  logic              sdram_req;
  logic              sdram_write;
  logic [31:0]       sdram_data_out;
  logic              sdram_ready;
  logic              sdram_done;

  logic              DDRAM_BUSY;
  logic [28:0]       DDRAM_ADDR;
  logic [7:0]        DDRAM_BURSTCNT;
  logic              DDRAM_RD;
  logic              DDRAM_WE;
  logic [63:0]       DDRAM_DIN;
  logic [7:0]        DDRAM_BE;
  logic [63:0]       DDRAM_DOUT;
  logic              DDRAM_DOUT_READY;

  modport slave (
    input  sdram_addr, sdram_data_in, sdram_req, sdram_write,
    output sdram_data_out, sdram_ready, sdram_done,
    input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    output DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
  );

  modport master (
    output sdram_addr, sdram_data_in, sdram_req, sdram_write,
    input  sdram_data_out, sdram_ready, sdram_done,
    output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    input  DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
  );
endinterface

// File: rtl/xbus_cache_ram.sv
// Simple dual-port block RAM: registered read, per-lane write enables.
module xbus_cache_ram #(
  parameter int AW     = 12,
  parameter int LANE_W = 32,
  parameter int LANES  = 2
) (
  input  logic                    cpu_clk,
  input  logic [AW-1:0]           wr_addr,
  input  logic [LANES-1:0]        wr_en,
  input  logic [LANES*LANE_W-1:0] wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic [LANES*LANE_W-1:0] rd_data
);

  logic [LANES*LANE_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge cpu_clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (wr_en[l]) mem[wr_addr][l*LANE_W +: LANE_W] <= wr_data[l*LANE_W +: LANE_W];
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/xbus_ddr_cache.sv
// Direct-mapped write-through, no-write-allocate read cache between xbus and DDR3.
// Define XBUS_CACHE_STATS_EN to build the hit/miss statistics counters.
module xbus_ddr_cache
  import lm3_mem_pkg::*;
#(
  parameter int                ADDR_W      = 22,
  parameter int                INDEX_W     = 12,
  parameter logic [ADDR_W-1:0] CACHE_LIMIT = 22'h3C0000,
  parameter logic [28:0]       DDR_BASE    = 29'h0
) (
  input  logic                  cpu_clk,
  input  logic                  reset,
  xbus_ddr_cache_if.slave       bus,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
);

  localparam int TAG_W = 29 - INDEX_W;

  cache_state_t      state, state_n;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic [31:0]       data_q;
  logic [28:0]       dword;
  logic [INDEX_W-1:0] idx, init_idx, wr_idx;
  logic              cacheable, half_hi, hit, hit_pulse;
  logic [TAG_W:0]    tag_rd, tag_wdata;
  logic              tag_we;
  logic [63:0]       data_rd, data_wdata;
  logic [1:0]        data_we;
  logic              ddr_rd, ddr_we;
  logic              is_rd_q, wr_chk_q, wr_hit_q, ready_q, done_q;
  logic [31:0]       data_out_q;

  // In IDLE the RAMs are addressed straight from the bus so LOOKUP has data in one cycle
  assign cur_addr  = (state == IDLE) ? bus.sdram_addr : addr_q;
  assign dword     = 29'(cur_addr[ADDR_W-1:1]) + DDR_BASE;
  assign idx       = dword[INDEX_W-1:0];
  assign wr_idx    = (state == INIT) ? init_idx : idx;
  assign cacheable = cur_addr < CACHE_LIMIT;
  assign half_hi   = cur_addr[0];
  assign hit       = cacheable && tag_rd[TAG_W] && (tag_rd[TAG_W-1:0] == dword[28:INDEX_W]);

  xbus_cache_ram #(.AW(INDEX_W), .LANE_W(TAG_W + 1), .LANES(1)) u_tag_ram (
    .cpu_clk (cpu_clk),
    .wr_addr (wr_idx),
    .wr_en   (tag_we),
    .wr_data (tag_wdata),
    .rd_addr (idx),
    .rd_data (tag_rd)
  );

  xbus_cache_ram #(.AW(INDEX_W), .LANE_W(32), .LANES(2)) u_data_ram (
    .cpu_clk (cpu_clk),
    .wr_addr (wr_idx),
    .wr_en   (data_we),
    .wr_data (data_wdata),
    .rd_addr (idx),
    .rd_data (data_rd)
  );

  always_ff @(posedge cpu_clk) begin
    if (reset) state <= INIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    tag_we     = 1'b0;
    tag_wdata  = {1'b1, dword[28:INDEX_W]};
    data_we    = 2'b00;
    data_wdata = {data_q, data_q};
    ddr_rd     = 1'b0;
    ddr_we     = 1'b0;
    hit_pulse  = 1'b0;
    case (state)
      INIT: begin
        tag_we    = 1'b1;
        tag_wdata = '0;
        if (init_idx == {INDEX_W{1'b1}}) state_n = IDLE;
      end
      IDLE: begin
        if (!ready_q && !done_q) begin
          if (bus.sdram_req)        state_n = cacheable ? LOOKUP : MISS_RD;
          else if (bus.sdram_write) state_n = WR;
        end
      end
      LOOKUP: begin
        if (hit) begin
          hit_pulse = 1'b1;
          state_n   = ACK;
        end else begin
          state_n   = MISS_RD;
        end
      end
      MISS_RD: begin
        ddr_rd = 1'b1;
        if (!bus.DDRAM_BUSY) state_n = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (bus.DDRAM_DOUT_READY) begin
          state_n = ACK;
          if (cacheable) begin
            tag_we     = 1'b1;
            data_we    = 2'b11;
            data_wdata = bus.DDRAM_DOUT;
          end
        end
      end
      WR: begin
        // First WR cycle only resolves the tag; the command goes out afterwards
        if (wr_chk_q) begin
          ddr_we = 1'b1;
          if (!bus.DDRAM_BUSY) begin
            state_n = ACK;
            if (wr_hit_q) data_we = half_hi ? 2'b10 : 2'b01;
          end
        end
      end
      ACK: begin
        if (is_rd_q ? !bus.sdram_req : !bus.sdram_write) state_n = IDLE;
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      init_idx   <= '0;
      is_rd_q    <= 1'b0;
      wr_chk_q   <= 1'b0;
      wr_hit_q   <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      if (state == INIT) init_idx <= init_idx + 1'b1;
      if (state == IDLE) begin
        is_rd_q  <= bus.sdram_req;
        wr_chk_q <= 1'b0;
      end
      if (state == WR && !wr_chk_q) begin
        wr_chk_q <= 1'b1;
        wr_hit_q <= hit;
      end
      if (hit_pulse) begin
        ready_q    <= 1'b1;
        data_out_q <= half_hi ? data_rd[63:32] : data_rd[31:0];
      end
      if (state == MISS_WAIT && bus.DDRAM_DOUT_READY) begin
        ready_q    <= 1'b1;
        data_out_q <= half_hi ? bus.DDRAM_DOUT[63:32] : bus.DDRAM_DOUT[31:0];
      end
      if (ddr_we && !bus.DDRAM_BUSY) done_q <= 1'b1;
      if (state == ACK && state_n == IDLE) begin
        ready_q <= 1'b0;
        done_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (state == IDLE) begin
      addr_q <= bus.sdram_addr;
      data_q <= bus.sdram_data_in;
    end
  end

  assign bus.DDRAM_RD       = ddr_rd;
  assign bus.DDRAM_WE       = ddr_we;
  assign bus.DDRAM_ADDR     = (ddr_rd || ddr_we) ? dword : 29'h0;
  assign bus.DDRAM_BURSTCNT = 8'd1;
  assign bus.DDRAM_DIN      = ddr_we ? {data_q, data_q} : 64'h0;
  assign bus.DDRAM_BE       = ddr_rd ? DDR_BE_ALL : (ddr_we ? ddr_be(half_hi) : 8'h00);
  assign bus.sdram_ready    = ready_q;
  assign bus.sdram_done     = done_q;
  assign bus.sdram_data_out = data_out_q;

`ifdef XBUS_CACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (hit_pulse)                hits_q   <= hits_q + 32'd1;
      if (state == LOOKUP && !hit)  misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = 32'h0;
  assign stat_misses = 32'h0;
`endif

endmodule

// File: tb/tb_xbus_ddr_cache.sv
// Directed bench for xbus_ddr_cache: DDR responder, tag model and read-data scoreboard.
module tb_xbus_ddr_cache;

  logic cpu_clk = 1'b0;
  logic reset;
  logic [31:0] stat_hits, stat_misses;

  xbus_ddr_cache_if #(.ADDR_W(22)) bus ();

  xbus_ddr_cache dut (
    .cpu_clk     (cpu_clk),
    .reset       (reset),
    .bus         (bus),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  always #5 cpu_clk = ~cpu_clk;

  int tests = 0;
  int fails = 0;

  logic [63:0] ddr_mem [logic [28:0]];
  bit          mv   [int];
  logic [16:0] mtag [int];
  int unsigned mh = 0, mm = 0;
  logic [31:0] sb [$];

  int  n;
  bit  got;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ddr_get(input logic [28:0] a);
    if (ddr_mem.exists(a)) return ddr_mem[a];
    return {3'b000, a, 3'b101, ~a};
  endfunction

  function automatic logic [31:0] exp_hits();
`ifdef XBUS_CACHE_STATS_EN
    return mh;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_misses();
`ifdef XBUS_CACHE_STATS_EN
    return mm;
`else
    return 32'h0;
`endif
  endfunction

  task automatic do_read(input logic [21:0] a, input string tag);
    logic [28:0] dw;
    logic [63:0] w;
    logic [31:0] exp_d;
    bit cach, exp_hit, rdy;
    int k, rd_n, dr_n, resp, lat, stray, exp_lat;
    int ix;
    dw      = {8'h00, a[21:1]};
    ix      = int'(dw[11:0]);
    cach    = a < 22'h3C0000;
    exp_hit = cach && mv.exists(ix) && mv[ix] && (mtag[ix] == dw[28:12]);
    w       = ddr_get(dw);
    sb.push_back(a[0] ? w[63:32] : w[31:0]);
    if (cach) begin
      if (exp_hit) mh++;
      else         mm++;
    end
    bus.sdram_addr = a;
    bus.sdram_req  = 1'b1;
    k = 0; rd_n = 0; dr_n = -1; resp = -1; lat = -1; stray = 0; rdy = 1'b0;
    while (!rdy && k < 60) begin
      @(negedge cpu_clk);
      k++;
      if (resp == 0) begin
        bus.DDRAM_DOUT       = ddr_get(dw);
        bus.DDRAM_DOUT_READY = 1'b1;
        dr_n = k;
        resp = -1;
      end else begin
        bus.DDRAM_DOUT_READY = 1'b0;
        if (resp > 0) resp--;
      end
      if (bus.DDRAM_WE || bus.sdram_done) stray++;
      if (bus.DDRAM_RD && !bus.DDRAM_BUSY) begin
        rd_n++;
        chk({tag, "_rd_addr"}, bus.DDRAM_ADDR, dw);
        chk({tag, "_rd_be"}, bus.DDRAM_BE, 8'hFF);
        resp = 2;
      end
      if (bus.sdram_ready) begin
        rdy = 1'b1;
        lat = k;
      end
    end
    chk({tag, "_ready"}, rdy, 1'b1);
    exp_d = sb.pop_front();
    if (rdy) chk({tag, "_data"}, bus.sdram_data_out, exp_d);
    exp_lat = exp_hit ? 2 : dr_n + 1;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_ddr_rds"}, rd_n, exp_hit ? 0 : 1);
    chk({tag, "_stray"}, stray, 0);
    if (cach && !exp_hit) begin
      mv[ix]   = 1'b1;
      mtag[ix] = dw[28:12];
    end
    bus.sdram_req = 1'b0;
    @(negedge cpu_clk);
    chk({tag, "_ready_drop"}, bus.sdram_ready, 1'b0);
    chk({tag, "_hits"}, stat_hits, exp_hits());
    chk({tag, "_misses"}, stat_misses, exp_misses());
  endtask

  task automatic do_write(input logic [21:0] a, input logic [31:0] d, input int busy_n,
                          input string tag);
    logic [28:0] dw;
    logic [63:0] old;
    bit dn;
    int k, we_n, first_we, acc_n, lat;
    dw  = {8'h00, a[21:1]};
    old = ddr_get(dw);
    bus.sdram_addr    = a;
    bus.sdram_data_in = d;
    bus.sdram_write   = 1'b1;
    bus.DDRAM_BUSY    = (busy_n > 0);
    k = 0; we_n = 0; first_we = -1; acc_n = -1; lat = -1; dn = 1'b0;
    while (!dn && k < 60) begin
      @(negedge cpu_clk);
      k++;
      if (bus.DDRAM_WE) begin
        we_n++;
        if (first_we < 0) first_we = k;
        bus.DDRAM_BUSY = (we_n <= busy_n);
        if (!bus.DDRAM_BUSY) begin
          acc_n = k;
          chk({tag, "_wr_addr"}, bus.DDRAM_ADDR, dw);
          chk({tag, "_wr_be"}, bus.DDRAM_BE, a[0] ? 8'hF0 : 8'h0F);
          chk({tag, "_wr_din"}, bus.DDRAM_DIN, {d, d});
          ddr_mem[dw] = a[0] ? {d, old[31:0]} : {old[63:32], d};
        end
      end
      if (bus.sdram_done) begin
        dn  = 1'b1;
        lat = k;
      end
    end
    chk({tag, "_done"}, dn, 1'b1);
    chk({tag, "_first_we"}, first_we, 2);
    chk({tag, "_we_cycles"}, we_n, busy_n + 1);
    chk({tag, "_latency"}, lat, acc_n + 1);
    bus.DDRAM_BUSY  = 1'b0;
    bus.sdram_write = 1'b0;
    @(negedge cpu_clk);
    chk({tag, "_done_drop"}, bus.sdram_done, 1'b0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                = 1'b1;
    bus.sdram_addr       = '0;
    bus.sdram_data_in    = '0;
    bus.sdram_req        = 1'b0;
    bus.sdram_write      = 1'b0;
    bus.DDRAM_BUSY       = 1'b0;
    bus.DDRAM_DOUT       = '0;
    bus.DDRAM_DOUT_READY = 1'b0;
    ddr_mem[29'h8]       = 64'hAAAA_BBBB_1111_2222;

    repeat (3) @(negedge cpu_clk);
    chk("rst_ready", bus.sdram_ready, 1'b0);
    chk("rst_done", bus.sdram_done, 1'b0);
    chk("rst_rd", bus.DDRAM_RD, 1'b0);
    chk("rst_we", bus.DDRAM_WE, 1'b0);
    chk("rst_burstcnt", bus.DDRAM_BURSTCNT, 8'd1);
    chk("rst_data_out", bus.sdram_data_out, 32'h0);
    chk("rst_be", bus.DDRAM_BE, 8'h00);
    chk("rst_hits", stat_hits, 32'h0);
    reset = 1'b0;
    repeat (4100) @(negedge cpu_clk);

    do_read(22'h000010, "cold");
    do_read(22'h000011, "reread");
    do_write(22'h000011, 32'hDEAD_BEEF, 3, "wr_busy");
    do_read(22'h000011, "rd_after_wr");
    do_read(22'h000010, "other_half");
    do_read(22'h3C0002, "io_1");
    do_read(22'h3C0002, "io_2");

    do_write(22'h000040, 32'h1234_5678, 1, "wr_miss");
    do_read(22'h000040, "no_alloc");
    do_read(22'h000041, "alloc_hit");
    do_read(22'h002010, "conflict");
    do_read(22'h000010, "evicted");

    bus.sdram_data_in = 32'hCAFE_0001;
    bus.sdram_write   = 1'b1;
    do_read(22'h000011, "both_rd");
    do_write(22'h000011, 32'hCAFE_0001, 0, "both_wr");
    do_read(22'h000011, "both_check");

    bus.sdram_addr = 22'h000020;
    bus.sdram_req  = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge cpu_clk);
      n++;
      if (bus.DDRAM_RD && !bus.DDRAM_BUSY) got = 1'b1;
    end
    chk("mid_rst_rd_issued", got, 1'b1);
    @(negedge cpu_clk);
    reset         = 1'b1;
    bus.sdram_req = 1'b0;
    @(negedge cpu_clk);
    chk("mid_rst_ready", bus.sdram_ready, 1'b0);
    chk("mid_rst_data_out", bus.sdram_data_out, 32'h0);
    chk("mid_rst_rd", bus.DDRAM_RD, 1'b0);
    reset                = 1'b0;
    bus.DDRAM_DOUT       = 64'h5555_6666_7777_8888;
    bus.DDRAM_DOUT_READY = 1'b1;
    @(negedge cpu_clk);
    bus.DDRAM_DOUT_READY = 1'b0;
    mv.delete();
    mtag.delete();
    mh = 0;
    mm = 0;
    repeat (4100) @(negedge cpu_clk);
    chk("late_dout_ready", bus.sdram_ready, 1'b0);
    chk("late_dout_data", bus.sdram_data_out, 32'h0);
    do_read(22'h000020, "post_rst_same");
    do_read(22'h000010, "post_rst_cleared");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
